serial_operand_feeder: RTL and testbench

- Upstream sequencer for the serial adder datapath.
- Accepts a pair of parallel operands through a valid/ready handshake and shifts them out LSB-first on two serial lines.
- Generates the adder's `load` enable, delayed to line up with the adder's input-register latency, then forces one idle cycle so the carry flop clears before the next word.
- Signals `done` when the downstream sum register holds the complete result.

---
 rtl/serial_pkg.sv | 18 +
 rtl/delay_line.sv | 36 +++
 rtl/serial_operand_feeder.sv | 103 ++++++++++
 tb/tb_serial_operand_feeder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state enum, default sizes and counter-width helper for the serial operand feeder
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_LAT   = 4;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/delay_line.sv
// rtl/delay_line.sv - LAT-deep single-bit delay with async active-low clear; wire when LAT=0
module delay_line
  import serial_pkg::*;
#(
  parameter int LAT = DEFAULT_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (LAT == 0) begin : g_pass
    assign q = d;
  end else begin : g_line
    logic [LAT-1:0] line_q;
    logic [LAT-1:0] line_d;
    logic [LAT:0]   line_ext;

    always_comb begin
      line_ext = {line_q, d};
      line_d   = line_ext[LAT-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        line_q <= '0;
      end else begin
        line_q <= line_d;
      end
    end

    assign q = line_q[LAT-1];
  end

endmodule

// File: rtl/serial_operand_feeder.sv
// rtl/serial_operand_feeder.sv - accepts operand pairs and shifts them LSB-first into the serial adder
// Optional SERIAL_FEED_CARRY_OUT_EN: shift one extra zero bit so the final carry lands in the sum.
module serial_operand_feeder
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LAT   = DEFAULT_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             a_ser,
  output logic             b_ser,
  output logic             load,
  output logic             busy,
  output logic             done
);

`ifdef SERIAL_FEED_CARRY_OUT_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = cnt_width((N > LAT) ? N : LAT);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   a_sh_q, a_sh_d;
  logic [N-1:0]   b_sh_q, b_sh_d;
  logic           en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHIFT;
          cnt_d   = '0;
          a_sh_d  = N'(in_a);
          b_sh_d  = N'(in_b);
        end
      end
      SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          state_d = (LAT == 0) ? GAP : DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(LAT - 1)) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
    end
  end

  // All handshake/status outputs come from the state register only.
  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == GAP);
  assign en       = (state_q == SHIFT);
  assign a_ser    = en & a_sh_q[0];
  assign b_ser    = en & b_sh_q[0];

  delay_line #(
    .LAT (LAT)
  ) u_delay_line (
    .clk   (clk),
    .rst_n (rst),
    .d     (en),
    .q     (load)
  );

endmodule

// File: tb/tb_serial_operand_feeder.sv
// tb/tb_serial_operand_feeder.sv - checks LAT=4 and LAT=0 feeders against a cycle-phase model plus a serial-adder sink
module tb_serial_operand_feeder;

  localparam int W = 4;
`ifdef SERIAL_FEED_CARRY_OUT_EN
  localparam int N        = W + 1;
  localparam int WRAP_SUM = 16;
  localparam int D0       = 9;
  localparam int D1       = 5;
  localparam int THR0     = 11;
`else
  localparam int N        = W;
  localparam int WRAP_SUM = 0;
  localparam int D0       = 8;
  localparam int D1       = 4;
  localparam int THR0     = 10;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [1:0]   in_ready, busy, a_ser, b_ser, load, done;

  serial_operand_feeder #(.WIDTH(W), .LAT(4)) u_lat4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_a(in_a), .in_b(in_b), .a_ser(a_ser[0]), .b_ser(b_ser[0]),
    .load(load[0]), .busy(busy[0]), .done(done[0])
  );

  serial_operand_feeder #(.WIDTH(W), .LAT(0)) u_lat0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_a(in_a), .in_b(in_b), .a_ser(a_ser[1]), .b_ser(b_ser[1]),
    .load(load[1]), .busy(busy[1]), .done(done[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int           ph[2];
  logic [N-1:0] ma[2], mb[2];
  int           acc_cyc[2], done_cyc[2], acc_gap[2], done_cnt[2];
  int           load_cnt[2], last_load_cnt[2];
  logic [N-1:0] sum[2], last_sum[2], abits[2], bbits[2];
  logic         carry[2];
  logic [15:0]  ha[2], hb[2];

  function automatic int lat_of(input int i);
    return (i == 0) ? 4 : 0;
  endfunction

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s[%0d] cyc=%0d got=%0d expected=%0d", nm, idx, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Phase model: ph = cycles since accept (1..N+L+1), 0 when idle.
  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        ph[i] = 0;
      end else if (ph[i] == 0) begin
        if (in_valid) begin
          ph[i] = 1;
          ma[i] = N'(in_a);
          mb[i] = N'(in_b);
        end
      end else if (ph[i] == N + lat_of(i) + 1) begin
        ph[i] = 0;
      end else begin
        ph[i] = ph[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int   p, l;
      logic ea, eb, ad, bd, s;
      p  = ph[i];
      l  = lat_of(i);
      ea = 1'b0;
      eb = 1'b0;
      if (p >= 1 && p <= N) begin
        ea = ma[i][p-1];
        eb = mb[i][p-1];
        abits[i][p-1] = a_ser[i];
        bbits[i][p-1] = b_ser[i];
      end
      if (p == 1) begin
        acc_gap[i]  = cyc - acc_cyc[i];
        acc_cyc[i]  = cyc;
        load_cnt[i] = 0;
      end
      chk("in_ready", i, int'(in_ready[i]), int'(p == 0));
      chk("busy", i, int'(busy[i]), int'(p != 0));
      chk("a_ser", i, int'(a_ser[i]), int'(ea));
      chk("b_ser", i, int'(b_ser[i]), int'(eb));
      chk("load", i, int'(load[i]), int'(p >= l + 1 && p <= N + l));
      chk("done", i, int'(done[i]), int'(p == N + l + 1));

      // Downstream sink: LAT-deep input register feeding a bit-serial adder.
      if (l == 0) begin
        ad = a_ser[i];
        bd = b_ser[i];
      end else begin
        ad = ha[i][l-1];
        bd = hb[i][l-1];
      end
      if (load[i]) begin
        s        = ad ^ bd ^ carry[i];
        carry[i] = (ad & bd) | (carry[i] & (ad ^ bd));
        sum[i]   = {s, sum[i][N-1:1]};
        load_cnt[i]++;
      end else begin
        carry[i] = 1'b0;
      end
      ha[i] = {ha[i][14:0], a_ser[i]};
      hb[i] = {hb[i][14:0], b_ser[i]};
      if (done[i]) begin
        last_sum[i]      = sum[i];
        last_load_cnt[i] = load_cnt[i];
        done_cyc[i]      = cyc;
        done_cnt[i]++;
      end
    end
  end

  task automatic run_op(input int a, input int b, input int settle);
    in_a     = W'(a);
    in_b     = W'(b);
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(settle);
  endtask

  initial begin
    int k, target, dc;
    for (int i = 0; i < 2; i++) begin
      sum[i] = '0; last_sum[i] = '0; carry[i] = 1'b0; ha[i] = '0; hb[i] = '0;
      acc_cyc[i] = 0; done_cyc[i] = 0; acc_gap[i] = 0; done_cnt[i] = 0;
      load_cnt[i] = 0; last_load_cnt[i] = 0; abits[i] = '0; bbits[i] = '0;
    end

    tick(3);
    chk("rst_in_ready", 0, int'(in_ready), 3);
    chk("rst_busy", 0, int'(busy), 0);
    chk("rst_load", 0, int'(load), 0);
    chk("rst_done", 0, int'(done), 0);
    chk("rst_ser", 0, int'({a_ser, b_ser}), 0);
    rst = 1'b1;
    tick(2);

    // Basic add 3+5
    run_op(3, 5, 14);
    chk("basic_abits", 0, int'(abits[0]), 3);
    chk("basic_bbits", 0, int'(bbits[0]), 5);
    chk("basic_sum", 0, int'(last_sum[0]), 8);
    chk("basic_sum", 1, int'(last_sum[1]), 8);
    chk("basic_done_lat", 0, done_cyc[0] - acc_cyc[0], D0);
    chk("basic_done_lat", 1, done_cyc[1] - acc_cyc[1], D1);
    chk("basic_load_len", 0, last_load_cnt[0], N);
    chk("basic_done_cnt", 0, done_cnt[0], 1);

    // Wrap / carry-out: 15+1
    run_op(15, 1, 14);
    chk("wrap_sum", 0, int'(last_sum[0]), WRAP_SUM);
    chk("wrap_sum", 1, int'(last_sum[1]), WRAP_SUM);
    chk("wrap_load_len", 0, last_load_cnt[0], N);
    chk("wrap_load_len", 1, last_load_cnt[1], N);

    // Back-to-back with in_valid held
    target   = done_cnt[0] + 2;
    in_a     = 4'd3;
    in_b     = 4'd5;
    in_valid = 1'b1;
    tick(1);
    in_a = 4'd2;
    in_b = 4'd2;
    k = 0;
    while (done_cnt[0] < target && k < 40) begin
      tick(1);
      k++;
    end
    in_valid = 1'b0;
    chk("b2b_wait", 0, int'(done_cnt[0] >= target), 1);
    chk("b2b_gap", 0, acc_gap[0], THR0);
    chk("b2b_sum", 0, int'(last_sum[0]), 4);
    tick(15);
    chk("b2b_sum", 1, int'(last_sum[1]), 4);

    // Reset mid-operation
    in_a     = 4'd3;
    in_b     = 4'd5;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(2);
    dc  = done_cnt[0] + done_cnt[1];
    rst = 1'b0;
    #1;
    chk("midrst_load", 0, int'(load), 0);
    chk("midrst_busy", 0, int'(busy), 0);
    chk("midrst_ser", 0, int'({a_ser, b_ser}), 0);
    chk("midrst_in_ready", 0, int'(in_ready), 3);
    chk("midrst_done", 0, int'(done), 0);
    tick(3);
    rst = 1'b1;
    tick(15);
    chk("midrst_no_done", 0, done_cnt[0] + done_cnt[1], dc);
    run_op(7, 1, 14);
    chk("post_rst_sum", 0, int'(last_sum[0]), 8);
    chk("post_rst_sum", 1, int'(last_sum[1]), 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
